// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch stage.
// Holds the FSM state encoding, the queue entry layout and the reset PC.
// No logic here; imported by fetch_queue and fetch_unit.
package fetch_pkg;

    // Address/data width used by the queue entry layout.
    localparam int FETCH_XLEN = 32;

    // Number of fetched instructions buffered ahead of decode.
    localparam int FETCH_QUEUE_DEPTH = 2;

    // First fetch address after reset.
    localparam logic [FETCH_XLEN-1:0] FETCH_RESET_PC = 32'h0000_0000;

    // ISSUE: may present a request. WAIT: one request outstanding, data kept.
    // DISCARD: one request outstanding whose data must be dropped.
    typedef enum logic [1:0] {
        ISSUE   = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_e;

    // One buffered instruction together with the address it was fetched from.
    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [31:0]           instr;
    } fetch_entry_t;

endpackage : fetch_pkg

// File: rtl/fetch_queue.sv
// Two-entry FIFO of fetched {pc, instr} pairs feeding the decode stage.
// Latency: a push is visible at the head on the next cycle; head is read combinationally.
// Backpressure: caller must not push when full or pop when empty; flush wins over push/pop.
module fetch_queue
    import fetch_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  fetch_entry_t entry_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output logic [1:0]   count_o,
    output fetch_entry_t head_o
);

    fetch_entry_t mem_q [FETCH_QUEUE_DEPTH];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   count_q;

    // Storage, pointers and occupancy; a flush simply rewinds everything to empty.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < FETCH_QUEUE_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else if (flush_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= entry_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            if (push_i && !pop_i) begin
                count_q <= count_q + 2'd1;
            end else if (!push_i && pop_i) begin
                count_q <= count_q - 2'd1;
            end
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

endmodule : fetch_queue

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, single-outstanding imem requests, 2-entry queue to decode.
// Latency: response in cycle N is offered to decode in cycle N+1; 2 cycles/instr with 1-cycle memory.
// Backpressure: stops requesting once the queue plus the outstanding request would overflow 2 entries.
module fetch_unit
    import fetch_pkg::*;
#(
    // Must match FETCH_XLEN, which sizes the queue entry.
    parameter int              XLEN     = FETCH_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = FETCH_RESET_PC
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    // instruction memory request channel
    output logic            imem_req_valid_o,
    input  logic            imem_req_ready_i,
    output logic [XLEN-1:0] imem_addr_o,
    // instruction memory response channel (in order, never backpressured)
    input  logic            imem_rsp_valid_i,
    input  logic [31:0]     imem_rdata_i,
    // control-flow redirect from execute
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    // decode interface
    output logic            if_valid_o,
    input  logic            if_ready_i,
    output logic [31:0]     if_instr_o,
    output logic [XLEN-1:0] if_pc_o,
    output logic [XLEN-1:0] if_pc4_o
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;

    logic            req_fire;
    logic            q_push;
    logic            q_pop;
    logic [1:0]      q_count;
    logic            q_has_head;
    fetch_entry_t    q_head;
    fetch_entry_t    q_entry;

    // A request is only ever presented when nothing is outstanding, so the
    // response can always land in the queue without overflowing it.
    assign imem_req_valid_o = rst_ni && (state_q == ISSUE)
                              && (32'(q_count) < FETCH_QUEUE_DEPTH);
    assign imem_addr_o      = pc_q;
    assign req_fire         = imem_req_valid_o && imem_req_ready_i;

    // Only data for a still-wanted request is kept; a redirect this cycle kills it.
    assign q_push  = (state_q == WAIT) && imem_rsp_valid_i && !redirect_i;
    assign q_entry = '{pc: req_pc_q, instr: imem_rdata_i};

    // Redirect hides the head immediately so decode never takes a wrong-path instruction.
    assign q_has_head = (q_count != 2'd0);
    assign if_valid_o = q_has_head && !redirect_i;
    assign q_pop      = if_valid_o && if_ready_i;

    // Head fields read as zero when empty, which also gives clean reset values.
    assign if_instr_o = q_has_head ? q_head.instr : 32'h0;
    assign if_pc_o    = q_has_head ? XLEN'(q_head.pc) : '0;
    assign if_pc4_o   = q_has_head ? XLEN'(q_head.pc) + XLEN'(4) : '0;

    // Next-state, PC and outstanding-address selection; redirect overrides everything.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        if (redirect_i) begin
            pc_d = redirect_pc_i & ~XLEN'(3);
            case (state_q)
                // A request accepted this very cycle is now wrong-path: drop its data.
                ISSUE:         state_d = req_fire ? DISCARD : ISSUE;
                // A response arriving with the redirect closes the old request here.
                WAIT, DISCARD: state_d = imem_rsp_valid_i ? ISSUE : DISCARD;
                default:       state_d = ISSUE;
            endcase
        end else begin
            case (state_q)
                ISSUE: begin
                    if (req_fire) begin
                        req_pc_d = pc_q;
                        pc_d     = pc_q + XLEN'(4);
                        state_d  = WAIT;
                    end
                end
                WAIT, DISCARD: begin
                    if (imem_rsp_valid_i) begin
                        state_d = ISSUE;
                    end
                end
                default: state_d = ISSUE;
            endcase
        end
    end

    // FSM, fetch PC and outstanding-request PC registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ISSUE;
            pc_q     <= RESET_PC;
            req_pc_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
        end
    end

    fetch_queue u_queue (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (q_push),
        .entry_i (q_entry),
        .pop_i   (q_pop),
        .flush_i (redirect_i),
        .count_o (q_count),
        .head_o  (q_head)
    );

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: behavioural model of the fetch stream plus directed scenarios.
module tb_fetch_unit;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i;
    logic [31:0] imem_addr_o;
    logic        imem_rsp_valid_i;
    logic [31:0] imem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        if_valid_o;
    logic        if_ready_i;
    logic [31:0] if_instr_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_pc4_o;

    always #5 clk_i = ~clk_i;

    fetch_unit dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_addr_o      (imem_addr_o),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rdata_i     (imem_rdata_i),
        .redirect_i       (redirect_i),
        .redirect_pc_i    (redirect_pc_i),
        .if_valid_o       (if_valid_o),
        .if_ready_i       (if_ready_i),
        .if_instr_o       (if_instr_o),
        .if_pc_o          (if_pc_o),
        .if_pc4_o         (if_pc4_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model: instructions delivered but not yet consumed, plus the single request in flight.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;
    ent_t        mq[$];
    logic        m_out;
    logic        m_live;
    logic [31:0] m_out_addr;
    logic [31:0] m_next_pc;
    int          m_hs_cnt;
    logic [31:0] rd_noise;

    // Outputs captured in the last cycle, for literal checks.
    logic        s_rv, s_ifv;
    logic [31:0] s_addr, s_pc, s_pc4, s_instr;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return 32'h0050_0093 ^ (a << 5);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_out      = 1'b0;
        m_live     = 1'b0;
        m_out_addr = 32'h0;
        m_next_pc  = 32'h0;
        m_hs_cnt   = 0;
    endtask

    task automatic reset_pulse();
        @(negedge clk_i);
        imem_req_ready_i = 1'b0;
        imem_rsp_valid_i = 1'b0;
        imem_rdata_i     = 32'h0;
        redirect_i       = 1'b0;
        redirect_pc_i    = 32'h0;
        if_ready_i       = 1'b0;
        rst_ni           = 1'b0;
        #1;
        chkb("rst_req_valid", imem_req_valid_o, 1'b0);
        chkb("rst_if_valid", if_valid_o, 1'b0);
        chk("rst_if_pc", if_pc_o, 32'h0);
        chk("rst_if_pc4", if_pc4_o, 32'h0);
        chk("rst_if_instr", if_instr_o, 32'h0);
        model_reset();
        @(posedge clk_i);
        @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    // One clock: drive inputs, compare against the model, then advance the model.
    task automatic cyc(input logic a_rdy, input logic a_rsp, input logic a_redir,
                       input logic [31:0] a_rpc, input logic a_ifr);
        logic        exp_ifv, exp_rv, hs, pop;
        logic [31:0] hs_addr, rdata;
        @(negedge clk_i);
        rdata            = word_of(m_out_addr) ^ rd_noise;
        imem_req_ready_i = a_rdy;
        imem_rsp_valid_i = a_rsp;
        imem_rdata_i     = rdata;
        redirect_i       = a_redir;
        redirect_pc_i    = a_rpc;
        if_ready_i       = a_ifr;
        #1;
        s_rv = imem_req_valid_o; s_addr = imem_addr_o; s_ifv = if_valid_o;
        s_pc = if_pc_o; s_pc4 = if_pc4_o; s_instr = if_instr_o;
        exp_ifv = (mq.size() != 0) && !a_redir;
        exp_rv  = !m_out && (mq.size() < 2);
        chkb("if_valid", if_valid_o, exp_ifv);
        if (exp_ifv) begin
            chk("if_pc", if_pc_o, mq[0].pc);
            chk("if_pc4", if_pc4_o, mq[0].pc + 32'd4);
            chk("if_instr", if_instr_o, mq[0].instr);
        end
        chkb("req_valid", imem_req_valid_o, exp_rv);
        if (exp_rv) chk("req_addr", imem_addr_o, m_next_pc);
        hs      = exp_rv && a_rdy;
        pop     = exp_ifv && a_ifr;
        hs_addr = m_next_pc;
        @(posedge clk_i);
        if (a_redir) begin
            mq.delete();
            m_next_pc = a_rpc & ~32'h3;
            m_live    = 1'b0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (a_rsp && m_out && m_live) mq.push_back('{m_out_addr, rdata});
            if (hs) m_next_pc = hs_addr + 32'd4;
        end
        if (a_rsp && m_out) m_out = 1'b0;
        if (hs) begin
            m_out      = 1'b1;
            m_out_addr = hs_addr;
            m_live     = !a_redir;
            m_hs_cnt++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni = 1'b0;
        rd_noise = 32'h0;
        imem_req_ready_i = 1'b0; imem_rsp_valid_i = 1'b0; imem_rdata_i = 32'h0;
        redirect_i = 1'b0; redirect_pc_i = 32'h0; if_ready_i = 1'b0;
        model_reset();

        // Basic fetch with a 1-cycle memory.
        reset_pulse();
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        chkb("t1_first_req", s_rv, 1'b1);
        chk("t1_first_addr", s_addr, 32'h0);
        cyc(1'b1, m_out, 1'b0, 32'h0, 1'b1);
        chkb("t1_wait_no_req", s_rv, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        chkb("t1_if_valid", s_ifv, 1'b1);
        chk("t1_if_pc", s_pc, 32'h0);
        chk("t1_if_pc4", s_pc4, 32'h4);
        chk("t1_if_instr", s_instr, 32'h0050_0093);
        chk("t1_next_addr", s_addr, 32'h4);

        // Decoder stalled: exactly two fetches, then the request line goes quiet.
        reset_pulse();
        repeat (10) cyc(1'b1, m_out, 1'b0, 32'h0, 1'b0);
        chk("t2_req_count", 32'(m_hs_cnt), 32'd2);
        chkb("t2_req_idle", s_rv, 1'b0);
        chk("t2_head_pc", s_pc, 32'h0);
        cyc(1'b1, m_out, 1'b0, 32'h0, 1'b1);
        chk("t2_pop0_pc", s_pc, 32'h0);
        chkb("t2_still_idle", s_rv, 1'b0);
        // Memory not ready for 3 cycles: address must hold at 0x8.
        cyc(1'b0, m_out, 1'b0, 32'h0, 1'b1);
        chk("t2_pop1_pc", s_pc, 32'h4);
        chk("t3_addr_hold0", s_addr, 32'h8);
        cyc(1'b0, m_out, 1'b0, 32'h0, 1'b1);
        chk("t3_addr_hold1", s_addr, 32'h8);
        cyc(1'b0, m_out, 1'b0, 32'h0, 1'b1);
        chk("t3_addr_hold2", s_addr, 32'h8);
        cyc(1'b1, m_out, 1'b0, 32'h0, 1'b1);
        chkb("t3_hs_valid", s_rv, 1'b1);
        chk("t3_hs_addr", s_addr, 32'h8);

        // Redirect while waiting for 0x8.
        cyc(1'b1, 1'b0, 1'b1, 32'h103, 1'b1);
        chkb("t4_redir_no_req", s_rv, 1'b0);
        cyc(1'b1, m_out, 1'b0, 32'h0, 1'b1);
        chkb("t4_discard_no_req", s_rv, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("t4_new_addr", s_addr, 32'h100);
        chkb("t4_no_stale_out", s_ifv, 1'b0);
        cyc(1'b1, m_out, 1'b0, 32'h0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("t4_first_pc", s_pc, 32'h100);

        // Redirect with response in the same cycle, then with a handshake.
        cyc(1'b1, m_out, 1'b1, 32'h200, 1'b1);
        chkb("t5_resp_dropped", s_ifv, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 32'h300, 1'b1);
        chk("t5_addr_200", s_addr, 32'h200);
        cyc(1'b1, m_out, 1'b0, 32'h0, 1'b1);
        chkb("t5_discard_no_req", s_rv, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("t5_addr_300", s_addr, 32'h300);
        chkb("t5_nothing_kept", s_ifv, 1'b0);

        // Reset while waiting with an entry queued; stale response afterwards.
        reset_pulse();
        repeat (3) cyc(1'b1, m_out, 1'b0, 32'h0, 1'b0);
        chk("t6_queued_pc", s_pc, 32'h0);
        reset_pulse();
        cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        chk("t6_restart_addr", s_addr, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        chkb("t6_stale_ignored", s_ifv, 1'b0);
        chkb("t6_req_again", s_rv, 1'b1);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] tgt;
            if ($urandom_range(0, 599) == 0) reset_pulse();
            rd_noise = $urandom;
            tgt = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                             : 32'($urandom);
            cyc($urandom_range(0, 3) != 0,
                m_out && ($urandom_range(0, 2) == 0),
                $urandom_range(0, 15) == 0,
                tgt,
                $urandom_range(0, 3) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_fetch_unit
